// File: rtl/scroll_text_overlay.sv
// ---------------------------------------------------------------------------
// scroll_text_overlay : vertically scrolling text block overlaid on video
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scroll_text_overlay #(
  parameter int TEXT_COLS       = 16,
  parameter int TEXT_ROWS       = 16,
  parameter int X0              = 448,
  parameter int START_Y         = 768,
  parameter int STEP_PX         = 1,
  parameter int FRAMES_PER_STEP = 1,
  parameter int LOOP            = 0,
  parameter int RW              = $clog2(TEXT_ROWS),
  parameter int CW              = $clog2(TEXT_COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mouse_left,
  input  logic [10:0]          vcount_in,
  input  logic [10:0]          hcount_in,
  input  logic                 vsync_in,
  input  logic                 vblnk_in,
  input  logic                 hsync_in,
  input  logic                 hblnk_in,
  input  logic [11:0]          rgb_in,
  input  logic [11:0]          fg_color,
  output logic [RW+CW-1:0]     char_xy,
  output logic [3:0]           char_line,
  input  logic [7:0]           char_pixels,
  output logic [10:0]          vcount_out,
  output logic [10:0]          hcount_out,
  output logic                 vsync_out,
  output logic                 vblnk_out,
  output logic                 hsync_out,
  output logic                 hblnk_out,
  output logic [11:0]          rgb_out,
  output logic                 done,
  output logic                 wrapped
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic signed [11:0] START_Y_S = 12'(START_Y);
  localparam logic signed [11:0] END_Y     = 12'(-(TEXT_ROWS * 16));
  localparam logic signed [11:0] STEP_S    = 12'(STEP_PX);
  localparam logic signed [11:0] X0_S      = 12'(X0);
  localparam logic signed [11:0] ROWS_PX   = 12'(TEXT_ROWS * 16);
  localparam logic signed [11:0] COLS_PX   = 12'(TEXT_COLS * 8);
  localparam logic [7:0]         DIV_LAST  = 8'(FRAMES_PER_STEP - 1);
  localparam bit                 LOOP_EN   = (LOOP != 0);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic signed [11:0] ypos;
  logic [7:0]         div_cnt;
  logic               vblnk_prev;
  logic               mouse_prev;
  logic               tick;
  logic               rise;
  logic               div_wrap;
  logic               step;
  logic               end_hit;
  logic               active;
  logic signed [11:0] y_stepped;

  assign tick      = vblnk_in & ~vblnk_prev;
  assign rise      = mouse_left & ~mouse_prev;
  assign div_wrap  = tick && (div_cnt == DIV_LAST);
  assign step      = (state == S_SCROLL) && div_wrap;
  assign y_stepped = ypos - STEP_S;
  assign end_hit   = step && (y_stepped <= END_Y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vblnk_prev <= 1'b0;
      mouse_prev <= 1'b0;
    end else begin
      state      <= next_state;
      vblnk_prev <= vblnk_in;
      mouse_prev <= mouse_left;
    end
  end

  // A step and a pause request in one cycle: the step is still applied below.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (tick) next_state = S_SCROLL;
        S_SCROLL: begin
          if (end_hit && !LOOP_EN) next_state = S_DONE;
          else if (rise)           next_state = S_PAUSE;
        end
        S_PAUSE:  if (rise) next_state = S_SCROLL;
        default:  next_state = S_DONE;
      endcase
    end
  end

  always_comb begin
    done   = (state == S_DONE);
    active = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      ypos    <= START_Y_S;
      div_cnt <= 8'd0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= 8'd0;
          ypos    <= START_Y_S;
        end
        S_SCROLL: begin
          if (tick) div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
          if (step) begin
            if (end_hit && LOOP_EN) begin
              ypos    <= START_Y_S;
              wrapped <= 1'b1;
            end else begin
              ypos <= y_stepped;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic signed [11:0] ry;
  logic signed [11:0] rx;
  logic               in_win;

  assign ry     = $signed({1'b0, vcount_in}) - ypos;
  assign rx     = $signed({1'b0, hcount_in}) - X0_S;
  assign in_win = active && !ry[11] && (ry < ROWS_PX) && !rx[11] && (rx < COLS_PX);

  always_comb begin
    char_xy   = '0;
    char_line = 4'd0;
    if (in_win) begin
      char_xy   = {ry[RW+3:4], rx[CW+2:3]};
      char_line = ry[3:0];
    end
  end

  logic [10:0] vcount_d1;
  logic [10:0] hcount_d1;
  logic        vsync_d1;
  logic        vblnk_d1;
  logic        hsync_d1;
  logic        hblnk_d1;
  logic [11:0] rgb_d1;
  logic        win_d1;
  logic [2:0]  rx_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_d1  <= 11'd0;
      hcount_d1  <= 11'd0;
      vsync_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      hsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      rgb_d1     <= 12'h000;
      win_d1     <= 1'b0;
      rx_d1      <= 3'd0;
      vcount_out <= 11'd0;
      hcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      vcount_d1  <= vcount_in;
      hcount_d1  <= hcount_in;
      vsync_d1   <= vsync_in;
      vblnk_d1   <= vblnk_in;
      hsync_d1   <= hsync_in;
      hblnk_d1   <= hblnk_in;
      rgb_d1     <= rgb_in;
      win_d1     <= in_win;
      rx_d1      <= rx[2:0];
      vcount_out <= vcount_d1;
      hcount_out <= hcount_d1;
      vsync_out  <= vsync_d1;
      vblnk_out  <= vblnk_d1;
      hsync_out  <= hsync_d1;
      hblnk_out  <= hblnk_d1;
      // Font row arrives one cycle after the address, aligned with stage 2.
      if (vblnk_d1 || hblnk_d1)                  rgb_out <= 12'h000;
      else if (win_d1 && char_pixels[3'd7 - rx_d1]) rgb_out <= fg_color;
      else                                       rgb_out <= rgb_d1;
    end
  end

endmodule

`default_nettype wire
